regbank_sb: RTL

- Parametrised multi-port register bank with an integrated per-register scoreboard; next generation of the core register bank.
- Sits between decode/issue and writeback.
- Provides NUM_RD combinational read ports and NUM_WR write ports with fixed priority.
- Issue marks a destination busy; writeback clears it. Exposes busy flags, a WAW stall and a busy count to the issue logic.

---
 rtl/regbank_sb_pkg.sv | 19 +
 rtl/regbank_sb_score.sv | 70 +++++++
 rtl/regbank_sb.sv | 91 +++++++++
 3 files changed

// File: rtl/regbank_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register bank.
// Optional same-cycle write-to-read bypass is enabled by defining REGBANK_BYPASS_EN.
package regbank_sb_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_REG_SEL  = $clog2(DEF_NUM_REGS);

  // Low bit of lane idx in a packed bus whose lanes are width bits wide.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // True when addr names a real, writable register (in range and not a hardwired zero).
  function automatic logic addr_live(input int addr, input int num_regs, input int zero_reg);
    return (addr < num_regs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regbank_sb_score.sv
// Per-register busy scoreboard: busy vector, WAW stall and a running busy count.
// With REGBANK_BYPASS_EN defined, a busy bit cleared this cycle does not stall an issue.
module regbank_sb_score
  import regbank_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_SEL  = $clog2(NUM_REGS),
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*REG_SEL-1:0] wr_addr,
  input  logic                      iss_en,
  input  logic [REG_SEL-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]       busy,
  output logic                      iss_stall,
  output logic [CNT_W-1:0]          busy_cnt
);

  logic [NUM_REGS-1:0] clear_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] next_busy;
  logic [CNT_W-1:0]    dec;
  logic [CNT_W-1:0]    next_cnt;
  logic                iss_live;
  logic                inc;

  // An accepted issue outranks a writeback to the same register, so the count
  // only drops for registers that really go from busy to idle.
  always_comb begin
    clear_vec = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] &&
          addr_live(int'(wr_addr[slice_lo(p, REG_SEL) +: REG_SEL]), NUM_REGS, ZERO_REG))
        clear_vec[wr_addr[slice_lo(p, REG_SEL) +: REG_SEL]] = 1'b1;
    end

    iss_live = addr_live(int'(iss_addr), NUM_REGS, ZERO_REG);
`ifdef REGBANK_BYPASS_EN
    iss_stall = iss_en && iss_live && busy[iss_addr] && !clear_vec[iss_addr];
`else
    iss_stall = iss_en && iss_live && busy[iss_addr];
`endif

    set_vec = '0;
    if (iss_en && !iss_stall && iss_live)
      set_vec[iss_addr] = 1'b1;

    next_busy = set_vec | (busy & ~clear_vec);
    inc       = |(set_vec & ~busy);
    dec       = '0;
    for (int r = 0; r < NUM_REGS; r++)
      dec = dec + CNT_W'(busy[r] & clear_vec[r] & ~set_vec[r]);
    next_cnt = busy_cnt + CNT_W'(inc) - dec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= next_busy;
      busy_cnt <= next_cnt;
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// Multi-port register bank with fixed-priority writes and an integrated busy scoreboard.
// Define REGBANK_BYPASS_EN to forward same-cycle write data to the read ports.
module regbank_sb
  import regbank_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_SEL  = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_RD*REG_SEL-1:0]        rd_addr,
  output logic [NUM_RD*WIDTH-1:0]          rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_SEL-1:0]        wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]          wr_data,
  input  logic                             iss_en,
  input  logic [REG_SEL-1:0]               iss_addr,
  output logic                             iss_stall,
  output logic [$clog2(NUM_REGS+1)-1:0]    busy_cnt
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  regbank_sb_score #(
    .NUM_REGS (NUM_REGS),
    .REG_SEL  (REG_SEL),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .CNT_W    ($clog2(NUM_REGS + 1))
  ) u_score (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .iss_stall (iss_stall),
    .busy_cnt  (busy_cnt)
  );

  // Ports are visited in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] &&
            addr_live(int'(wr_addr[slice_lo(p, REG_SEL) +: REG_SEL]), NUM_REGS, ZERO_REG))
          regs[wr_addr[slice_lo(p, REG_SEL) +: REG_SEL]] <= wr_data[slice_lo(p, WIDTH) +: WIDTH];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_SEL-1:0] sel;
    logic [WIDTH-1:0]   port_data;
    logic               port_busy;

    assign sel = rd_addr[p*REG_SEL +: REG_SEL];

    // Dead addresses (zero register, out of range) read as idle zero before any forwarding.
    always_comb begin
      port_data = '0;
      port_busy = 1'b0;
      if (addr_live(int'(sel), NUM_REGS, ZERO_REG)) begin
        port_data = regs[sel];
        port_busy = busy[sel];
`ifdef REGBANK_BYPASS_EN
        for (int q = 0; q < NUM_WR; q++) begin
          if (wr_en[q] && (wr_addr[slice_lo(q, REG_SEL) +: REG_SEL] == sel)) begin
            port_data = wr_data[slice_lo(q, WIDTH) +: WIDTH];
            port_busy = 1'b0;
          end
        end
`endif
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = port_data;
    assign rd_busy[p]                = port_busy;
  end

endmodule
